// File: rtl/suma_display_mux_pkg.sv
// ============================================================================
// suma_display_mux_pkg : shared segment glyphs, seg7 decoder and clog2 helper
// Rev 1.0
// ============================================================================
`default_nettype none

package suma_display_mux_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_e;

   // Active-low glyphs, segment a at bit 0
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r++;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/suma_display_mux_bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : sequential double-dabble converter, one bit per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
   import suma_display_mux_pkg::*;
#(
   parameter int BW   = 5,
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BW-1:0]     bin,
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] bcd
);

   localparam int DW = 4 * NDIG;
   localparam int CW = clog2(BW + 1);

   conv_state_e         state;
   logic [DW+BW-1:0]    sreg;
   logic [DW+BW-1:0]    adj;
   logic [DW+BW-1:0]    shifted;
   logic [CW-1:0]       cnt;

   always_comb begin
      adj = sreg;
      for (int i = 0; i < NDIG; i++) begin
         if (sreg[BW+4*i +: 4] >= 4'd5)
            adj[BW+4*i +: 4] = sreg[BW+4*i +: 4] + 4'd3;
      end
      shifted = {adj[DW+BW-2:0], 1'b0};
   end

   // done and bcd are combinational so the caller can capture the result on
   // the very edge that returns the FSM to IDLE.
   assign done = (state == CONV) && (cnt == CW'(1));
   assign bcd  = shifted[BW +: DW];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sreg  <= {{DW{1'b0}}, bin};
                  cnt   <= CW'(BW);
                  state <= CONV;
                  busy  <= 1'b1;
               end
            end
            CONV: begin
               sreg <= shifted;
               cnt  <= cnt - CW'(1);
               if (done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/suma_display_mux.sv
// ============================================================================
// suma_display_mux : A+B adder with BCD conversion and multiplexed 7-seg scan
// Optional leading-zero blanking with SUMA_DISPLAY_BLANK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module suma_display_mux
   import suma_display_mux_pkg::*;
#(
   parameter int W           = 4,
   parameter int NDIG        = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   input  logic            load,
   output logic            busy,
   output logic [6:0]      D,
   output logic [NDIG-1:0] An
);

   localparam int SW = W + 1;
   localparam int RW = clog2(REFRESH_DIV);
   localparam int IW = (NDIG > 1) ? clog2(NDIG) : 1;

   logic [SW-1:0]       sum;
   logic                conv_done;
   logic [4*NDIG-1:0]   conv_bcd;
   logic [4*NDIG-1:0]   disp;
   logic [4*NDIG-1:0]   disp_next;
   logic [RW-1:0]       rcnt;
   logic [IW-1:0]       idx;
   logic [IW-1:0]       idx_next;
   logic                wrap;
   logic [3:0]          digit;
   logic                blank;
   logic                above_zero;
   logic [NDIG-1:0]     an_next;
   logic [6:0]          seg_next;

   assign sum = SW'(A) + SW'(B);

   bin2bcd_seq #(
      .BW   (SW),
      .NDIG (NDIG)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (load),
      .bin   (sum),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   assign disp_next = conv_done ? conv_bcd : disp;
   assign wrap      = (rcnt == RW'(REFRESH_DIV - 1));
   assign idx_next  = !wrap ? idx : ((idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1));

   // Outputs are decoded from next-state values so An and D move together
   // with the scan index and with the display update.
   always_comb begin
      digit      = 4'd0;
      an_next    = '1;
      blank      = 1'b0;
      above_zero = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_next == IW'(i)) begin
            digit      = disp_next[4*i +: 4];
            an_next[i] = 1'b0;
         end
      end
`ifdef SUMA_DISPLAY_BLANK_EN
      for (int i = NDIG - 1; i >= 0; i--) begin
         above_zero = above_zero & (disp_next[4*i +: 4] == 4'd0);
         if ((idx_next == IW'(i)) && (i != 0) && above_zero)
            blank = 1'b1;
      end
`else
      blank = above_zero & 1'b0;
`endif
      seg_next = blank ? SEG_BLANK : seg7(digit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp <= '0;
         rcnt <= '0;
         idx  <= '0;
         An   <= {{(NDIG-1){1'b1}}, 1'b0};
         D    <= SEG_0;
      end else begin
         disp <= disp_next;
         rcnt <= wrap ? '0 : rcnt + RW'(1);
         idx  <= idx_next;
         An   <= an_next;
         D    <= seg_next;
      end
   end

endmodule

`default_nettype wire
